// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the core's data-memory port.
// Word-organised, byte-write-enabled data RAM with a request/grant/valid
// handshake and a fixed, parameterised number of wait states per access.
// Optional address-window checking is compiled in with DMEM_RANGE_CHECK_EN;
// without it the upper address bits simply alias into the array.

module dmem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_we,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    output logic        data_err
);

    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam bit          NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0]  WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              wait_cnt;
    logic [3:0]              wait_cnt_next;
    logic                    accept;
    logic                    commit;

    logic [ADDR_WIDTH-1:0]   word_q;
    logic [31:0]             wdata_q;
    logic [3:0]              we_q;

    logic [ADDR_WIDTH-1:0]   acc_word;
    logic [31:0]             acc_wdata;
    logic [3:0]              acc_we;
    logic                    acc_err;

    logic [31:0]             mem [0:DEPTH-1];

    logic                    unused_addr_bits;

    assign unused_addr_bits = ^{data_addr[31:ADDR_WIDTH+2], data_addr[1:0]};

    // State and wait-counter register; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Next-state logic plus handshake outputs; commit marks the edge entering RESP.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        data_gnt      = 1'b0;
        data_rvalid   = 1'b0;
        accept        = 1'b0;
        commit        = 1'b0;
        case (state)
            IDLE: begin
                if (data_req && !rst) begin
                    data_gnt = 1'b1;
                    accept   = 1'b1;
                    if (NO_WAIT) begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next    = WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = RESP;
                    commit     = !rst;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            RESP: begin
                data_rvalid = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the request on the accept edge so the requester may drop it after the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q  <= '0;
            wdata_q <= 32'h0;
            we_q    <= 4'h0;
        end else if (accept) begin
            word_q  <= data_addr[ADDR_WIDTH+1:2];
            wdata_q <= data_wdata;
            we_q    <= data_we;
        end
    end

    // With zero wait states the accept edge is also the access edge, so use the live request.
    assign acc_word  = NO_WAIT ? data_addr[ADDR_WIDTH+1:2] : word_q;
    assign acc_wdata = NO_WAIT ? data_wdata : wdata_q;
    assign acc_we    = NO_WAIT ? data_we : we_q;

`ifdef DMEM_RANGE_CHECK_EN
    logic addr_mismatch;
    logic err_q;

    assign addr_mismatch = (data_addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]);

    // Remember whether the accepted address fell outside the RAM window.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= addr_mismatch;
        end
    end

    assign acc_err  = NO_WAIT ? addr_mismatch : err_q;
    assign data_err = data_rvalid & err_q;
`else
    assign acc_err  = 1'b0;
    assign data_err = 1'b0;
`endif

    // Read port: loads return the addressed word, stores and rejected accesses return zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_rdata <= 32'h0;
        end else if (commit) begin
            if ((acc_we == 4'b0000) && !acc_err) begin
                data_rdata <= mem[acc_word];
            end else begin
                data_rdata <= 32'h0;
            end
        end
    end

    // Byte-lane write into the array; unselected lanes keep their contents and memory is never reset.
    always_ff @(posedge clk) begin
        if (commit && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_we[i]) begin
                    mem[acc_word][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
// (ADDR_WIDTH=10, WAIT_STATES=1, BASE_ADDR=0). Expectations for the
// address-window case follow DMEM_RANGE_CHECK_EN when it is defined.

module tb_dmem_responder;

    localparam int unsigned WS = 1;

    logic        clk;
    logic        rst;
    logic        data_req;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_we;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_err;

    int n_checks;
    int n_errors;

    dmem_responder #(
        .ADDR_WIDTH (10),
        .WAIT_STATES(WS),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_req   (data_req),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_we    (data_we),
        .data_gnt   (data_gnt),
        .data_rvalid(data_rvalid),
        .data_rdata (data_rdata),
        .data_err   (data_err)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_stimulus(input logic req, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] we);
        data_req   = req;
        data_addr  = addr;
        data_wdata = wdata;
        data_we    = we;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] we, output logic [31:0] rdata,
                             output logic err, output int lat);
        logic got;
        got   = 1'b0;
        lat   = 0;
        rdata = 32'h0;
        err   = 1'b0;
        @(negedge clk);
        apply_stimulus(1'b1, addr, wdata, we);
        #1;
        for (int k = 0; k < 16 && !got; k++) begin
            if (data_gnt) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                #1;
            end
        end
        if (!got) begin
            check_output("gnt_timeout", {31'b0, got}, 32'd1);
            apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0);
            return;
        end
        @(negedge clk);
        apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0);
        lat = 1;
        got = 1'b0;
        for (int k = 0; k < 16 && !got; k++) begin
            #1;
            if (data_rvalid) begin
                got   = 1'b1;
                rdata = data_rdata;
                err   = data_err;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        if (!got) begin
            check_output("rvalid_timeout", {31'b0, got}, 32'd1);
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          grants;
    int          rvs;
    int          bad;
    int          quiet;

    // Directed sequence: reset, word and lane writes, streaming, reset abort, aliasing.
    initial begin
        n_checks = 0;
        n_errors = 0;
        $display("[TB] dmem_responder directed test starting");

        rst = 1'b1;
        apply_stimulus(1'b1, 32'h10, 32'h0, 4'h0);
        repeat (2) begin
            @(negedge clk);
            check_output("reset_gnt", {31'b0, data_gnt}, 32'd0);
            check_output("reset_rvalid", {31'b0, data_rvalid}, 32'd0);
            check_output("reset_rdata", data_rdata, 32'h0);
            check_output("reset_err", {31'b0, data_err}, 32'd0);
        end
        rst = 1'b0;
        #1;
        check_output("first_gnt", {31'b0, data_gnt}, 32'd1);
        @(negedge clk);
        apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(negedge clk);

        do_access(32'h20, 32'h0000_0000, 4'b1111, rd, er, lat);
        check_output("init20_lat", 32'(lat), 32'(WS + 1));

        do_access(32'h10, 32'hDEAD_BEEF, 4'b1111, rd, er, lat);
        check_output("wr_word_lat", 32'(lat), 32'(WS + 1));
        check_output("wr_word_rdata", rd, 32'h0);
        check_output("wr_word_err", {31'b0, er}, 32'd0);

        do_access(32'h10, 32'h0, 4'b0000, rd, er, lat);
        check_output("rd_word_lat", 32'(lat), 32'(WS + 1));
        check_output("rd_word_rdata", rd, 32'hDEAD_BEEF);

        do_access(32'h10, 32'h5555_5555, 4'b0100, rd, er, lat);
        do_access(32'h10, 32'h0, 4'b0000, rd, er, lat);
        check_output("rd_byte2", rd, 32'hDE55_BEEF);

        do_access(32'h10, 32'h1234_1234, 4'b1100, rd, er, lat);
        do_access(32'h10, 32'h0, 4'b0000, rd, er, lat);
        check_output("rd_half_hi", rd, 32'h1234_BEEF);

        @(negedge clk);
        apply_stimulus(1'b1, 32'h10, 32'h0, 4'h0);
        grants = 0;
        rvs    = 0;
        bad    = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (data_gnt) grants++;
            if (data_rvalid) begin
                rvs++;
                if (data_rdata !== 32'h1234_BEEF) bad++;
            end
            if (data_gnt !== ((i % 3) == 0)) bad++;
            if (data_rvalid !== ((i % 3) == 2)) bad++;
            @(negedge clk);
        end
        apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0);
        check_output("stream_grants", 32'(grants), 32'd4);
        check_output("stream_rvalids", 32'(rvs), 32'd4);
        check_output("stream_pattern", 32'(bad), 32'd0);

        @(negedge clk);
        apply_stimulus(1'b1, 32'h20, 32'hCAFE_F00D, 4'b1111);
        #1;
        check_output("abort_gnt", {31'b0, data_gnt}, 32'd1);
        @(negedge clk);
        apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0);
        rst = 1'b1;
        #1;
        check_output("abort_wait_rvalid", {31'b0, data_rvalid}, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        quiet = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (data_rvalid) quiet++;
            @(negedge clk);
        end
        check_output("abort_no_rvalid", 32'(quiet), 32'd0);
        do_access(32'h20, 32'h0, 4'b0000, rd, er, lat);
        check_output("abort_rd20", rd, 32'h0000_0000);

        do_access(32'h0000_4010, 32'hA5A5_A5A5, 4'b1111, rd, er, lat);
        check_output("range_wr_rdata", rd, 32'h0);
`ifdef DMEM_RANGE_CHECK_EN
        check_output("range_wr_err", {31'b0, er}, 32'd1);
`else
        check_output("range_wr_err", {31'b0, er}, 32'd0);
`endif
        do_access(32'h10, 32'h0, 4'b0000, rd, er, lat);
`ifdef DMEM_RANGE_CHECK_EN
        check_output("range_rd10", rd, 32'h1234_BEEF);
`else
        check_output("range_rd10", rd, 32'hA5A5_A5A5);
`endif
        check_output("range_rd10_err", {31'b0, er}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
